audio_dma: RTL and testbench

Memory-to-FIFO sample sequencer for the audio path, in the `clk_sys` domain. It fetches packed stereo words (`{left[15:0], right[15:0]}`) from a CPU-programmed ring buffer over a single-word read port and pushes them into the audio output FIFO's write side. Refills are scheduled from the FIFO's write-side fill level, so the CPU only programs base and length, then services a wrap/done interrupt.

---
 rtl/audio_dma.sv | 213 +++++++++++++++++++++
 tb/tb_audio_dma.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_dma.sv
// Ring-buffer sample fetcher: reads packed stereo words from memory and
// pushes them into the audio output FIFO, refilling in bursts below a water mark.
module audio_dma #(
  parameter int LOW_WATER = 1024,
  parameter int BURST     = 64,
  parameter int LEN_W     = 20
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        cfg_wr,
  input  logic [1:0]  cfg_addr,
  input  logic [31:0] cfg_wdata,
  output logic [31:0] cfg_rdata,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic [11:0] fifo_level,
  input  logic        fifo_full,
  output logic        sample_wr,
  output logic [31:0] sample_data,
  output logic        irq
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_REQ   = 3'd2,
    ST_PUSH  = 3'd3,
    ST_END   = 3'd4
  } state_t;

  localparam logic [11:0] LOW_WATER_C = 12'(LOW_WATER);
  localparam logic [11:0] BURST_C     = 12'(BURST);

  state_t           state_r, state_nxt_s;
  logic             enable_r, loop_r, irq_en_r, busy_r, irq_pend_r;
  logic [31:0]      base_r, base_act_r;
  logic [LEN_W-1:0] len_r, len_act_r, pos_r, pos_nxt_s, pos_inc_s;
  logic [11:0]      batch_r, batch_nxt_s;
  logic             start_s, stop_s, en_clr_s, end_s, wr_nxt_s, ack_s;
  logic             irq_pend_nxt_s, irq_en_nxt_s;
  logic             mem_req_r, sample_wr_r, irq_r;
  logic [31:0]      mem_addr_r, sample_data_r, cfg_rdata_r;

  assign start_s   = cfg_wr && (cfg_addr == 2'd0) && cfg_wdata[0] && !enable_r;
  assign ack_s     = mem_req_r && mem_ack;
  assign pos_inc_s = pos_r + {{(LEN_W-1){1'b0}}, 1'b1};

  assign mem_req     = mem_req_r;
  assign mem_addr    = mem_addr_r;
  assign sample_wr   = sample_wr_r;
  assign sample_data = sample_data_r;
  assign irq         = irq_r;
  assign cfg_rdata   = cfg_rdata_r;

  // Sequencer next-state and per-cycle control decisions.
  // A FIFO write is decided one cycle ahead (wr_nxt_s) so sample_wr is a flop;
  // PUSH commits pos/batch in the cycle the write strobe is high.
  always_comb begin
    state_nxt_s = state_r;
    pos_nxt_s   = pos_r;
    batch_nxt_s = batch_r;
    wr_nxt_s    = 1'b0;
    end_s       = 1'b0;
    stop_s      = 1'b0;
    en_clr_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (busy_r) state_nxt_s = ST_CHECK;
        else        state_nxt_s = ST_IDLE;
      end
      ST_CHECK: begin
        if (!enable_r) begin
          state_nxt_s = ST_IDLE;
          stop_s      = 1'b1;
        end else if (pos_r == len_act_r) begin
          state_nxt_s = ST_END;
        end else if (fifo_level < LOW_WATER_C) begin
          batch_nxt_s = BURST_C;
          state_nxt_s = ST_REQ;
        end else begin
          state_nxt_s = ST_CHECK;
        end
      end
      ST_REQ: begin
        if (ack_s) begin
          state_nxt_s = ST_PUSH;
          wr_nxt_s    = !fifo_full;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_PUSH: begin
        if (sample_wr_r) begin
          pos_nxt_s   = pos_inc_s;
          batch_nxt_s = batch_r - 12'd1;
          if (!enable_r) begin
            state_nxt_s = ST_IDLE;
            stop_s      = 1'b1;
          end else if ((batch_r != 12'd1) && (pos_inc_s != len_act_r)) begin
            state_nxt_s = ST_REQ;
          end else begin
            state_nxt_s = ST_CHECK;
          end
        end else begin
          wr_nxt_s = !fifo_full;
        end
      end
      ST_END: begin
        end_s = 1'b1;
        if (loop_r && enable_r) begin
          pos_nxt_s   = {LEN_W{1'b0}};
          state_nxt_s = ST_CHECK;
        end else begin
          state_nxt_s = ST_IDLE;
          stop_s      = 1'b1;
          en_clr_s    = 1'b1;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Interrupt bookkeeping; an END in the same cycle as a STATUS write wins.
  always_comb begin
    irq_pend_nxt_s = irq_pend_r;
    irq_en_nxt_s   = irq_en_r;
    if (end_s) begin
      irq_pend_nxt_s = 1'b1;
    end else if (cfg_wr && (cfg_addr == 2'd3)) begin
      irq_pend_nxt_s = 1'b0;
    end else begin
      irq_pend_nxt_s = irq_pend_r;
    end
    if (cfg_wr && (cfg_addr == 2'd0)) irq_en_nxt_s = cfg_wdata[2];
    else                              irq_en_nxt_s = irq_en_r;
  end

  // FSM state register.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state_r <= ST_IDLE;
    else          state_r <= state_nxt_s;
  end

  // Configuration, shadow/active copies and transfer progress.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      enable_r   <= 1'b0;
      loop_r     <= 1'b0;
      irq_en_r   <= 1'b0;
      busy_r     <= 1'b0;
      irq_pend_r <= 1'b0;
      base_r     <= 32'd0;
      base_act_r <= 32'd0;
      len_r      <= {LEN_W{1'b0}};
      len_act_r  <= {LEN_W{1'b0}};
      pos_r      <= {LEN_W{1'b0}};
      batch_r    <= 12'd0;
    end else begin
      irq_pend_r <= irq_pend_nxt_s;
      irq_en_r   <= irq_en_nxt_s;
      batch_r    <= batch_nxt_s;
      if (cfg_wr && (cfg_addr == 2'd0)) loop_r <= cfg_wdata[1];
      if (cfg_wr && (cfg_addr == 2'd1)) base_r <= {cfg_wdata[31:2], 2'b00};
      if (cfg_wr && (cfg_addr == 2'd2)) len_r  <= cfg_wdata[LEN_W-1:0];
      if (start_s)                           enable_r <= 1'b1;
      else if (en_clr_s)                     enable_r <= 1'b0;
      else if (cfg_wr && (cfg_addr == 2'd0)) enable_r <= cfg_wdata[0];
      if (start_s) begin
        base_act_r <= base_r;
        len_act_r  <= len_r;
        pos_r      <= {LEN_W{1'b0}};
        busy_r     <= 1'b1;
      end else begin
        pos_r <= pos_nxt_s;
        if (stop_s) busy_r <= 1'b0;
      end
    end
  end

  // Memory port, FIFO write side, interrupt line and register readback.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      mem_req_r     <= 1'b0;
      mem_addr_r    <= 32'd0;
      sample_wr_r   <= 1'b0;
      sample_data_r <= 32'd0;
      irq_r         <= 1'b0;
      cfg_rdata_r   <= 32'd0;
    end else begin
      sample_wr_r <= wr_nxt_s;
      irq_r       <= irq_pend_nxt_s & irq_en_nxt_s;
      if ((state_nxt_s == ST_REQ) && (state_r != ST_REQ)) begin
        mem_req_r  <= 1'b1;
        mem_addr_r <= base_act_r + {{(30-LEN_W){1'b0}}, pos_nxt_s, 2'b00};
      end else if (ack_s) begin
        mem_req_r <= 1'b0;
      end
      if ((state_r == ST_REQ) && ack_s) sample_data_r <= mem_rdata;
      case (cfg_addr)
        2'd0:    cfg_rdata_r <= {29'd0, irq_en_r, loop_r, enable_r};
        2'd1:    cfg_rdata_r <= base_r;
        2'd2:    cfg_rdata_r <= {{(32-LEN_W){1'b0}}, len_r};
        2'd3:    cfg_rdata_r <= {irq_pend_r, busy_r, {(30-LEN_W){1'b0}}, pos_r};
        default: cfg_rdata_r <= 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_dma.sv
// Directed bench for audio_dma: zero/long-wait memory responder, FIFO level and
// full stimulus, and per-scenario checks against hand-computed values.
module tb_audio_dma;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        cfg_wr;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [11:0] fifo_level;
  logic        fifo_full;
  logic        sample_wr;
  logic [31:0] sample_data;
  logic        irq;

  int total = 0;
  int bad   = 0;
  int ack_wait = 1;
  logic [31:0] addr_q[$];
  logic [31:0] data_q[$];
  time         wr_t_q[$];
  localparam logic [31:0] PAT = 32'hA5A5_0000;

  audio_dma dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .fifo_level(fifo_level), .fifo_full(fifo_full), .sample_wr(sample_wr),
    .sample_data(sample_data), .irq(irq)
  );

  always #5 clk_sys = ~clk_sys;

  // memory responder: ack arrives ack_wait cycles after mem_req rises
  initial begin
    int cnt;
    cnt = 0;
    mem_ack = 1'b0;
    mem_rdata = 32'd0;
    forever begin
      @(posedge clk_sys); #1;
      mem_ack = 1'b0;
      if (mem_req) begin
        cnt++;
        if (cnt == ack_wait + 1) begin
          mem_ack = 1'b1;
          mem_rdata = mem_addr ^ PAT;
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // transaction monitor
  initial begin
    forever begin
      @(negedge clk_sys);
      if (mem_req && mem_ack) addr_q.push_back(mem_addr);
      if (sample_wr) begin
        data_q.push_back(sample_data);
        wr_t_q.push_back($time);
      end
    end
  end

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk_sys);
    cfg_wr = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(negedge clk_sys);
    cfg_wr = 1'b0;
  endtask

  task automatic cfg_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk_sys);
    cfg_addr = a;
    @(negedge clk_sys);
    d = cfg_rdata;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic test_reset;
    logic [31:0] d;
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_mem_req got=%h exp=0", mem_req); end
    total++; if (mem_addr !== 32'd0) begin bad++; $display("FAIL rst_mem_addr got=%h exp=0", mem_addr); end
    total++; if (sample_wr !== 1'b0) begin bad++; $display("FAIL rst_sample_wr got=%h exp=0", sample_wr); end
    total++; if (sample_data !== 32'd0) begin bad++; $display("FAIL rst_sample_data got=%h exp=0", sample_data); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL rst_irq got=%h exp=0", irq); end
    total++; if (cfg_rdata !== 32'd0) begin bad++; $display("FAIL rst_cfg_rdata got=%h exp=0", cfg_rdata); end
    @(negedge clk_sys);
    reset_n = 1'b1;
    cfg_read(2'd3, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL rst_status got=%h exp=0", d); end
  endtask

  task automatic test_basic;
    int a0, d0;
    logic [31:0] d, ea;
    a0 = addr_q.size(); d0 = data_q.size();
    ack_wait = 1; fifo_level = 12'd0; fifo_full = 1'b0;
    cfg_write(2'd1, 32'h0000_1000);
    cfg_write(2'd2, 32'd4);
    cfg_write(2'd0, 32'd1);
    wait_cycles(40);
    total++;
    if (addr_q.size() - a0 != 4 || data_q.size() - d0 != 4) begin
      bad++; $display("FAIL basic_count got=%0d/%0d exp=4/4", addr_q.size() - a0, data_q.size() - d0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        ea = 32'h0000_1000 + 32'(4 * i);
        total++; if (addr_q[a0+i] !== ea) begin bad++; $display("FAIL basic_addr%0d got=%h exp=%h", i, addr_q[a0+i], ea); end
        total++; if (data_q[d0+i] !== (ea ^ PAT)) begin bad++; $display("FAIL basic_data%0d got=%h exp=%h", i, data_q[d0+i], ea ^ PAT); end
      end
      total++; if (wr_t_q[d0+1] - wr_t_q[d0] != 30) begin bad++; $display("FAIL basic_cadence got=%0t exp=30", wr_t_q[d0+1] - wr_t_q[d0]); end
    end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL basic_irq_masked got=%h exp=0", irq); end
    cfg_read(2'd3, d);
    total++; if (d !== 32'h8000_0004) begin bad++; $display("FAIL basic_status got=%h exp=80000004", d); end
    cfg_write(2'd0, 32'd4);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL basic_irq got=%h exp=1", irq); end
    cfg_read(2'd0, d);
    total++; if (d !== 32'h0000_0004) begin bad++; $display("FAIL basic_ctrl got=%h exp=4", d); end
    cfg_write(2'd3, 32'd0);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL basic_irq_clr got=%h exp=0", irq); end
  endtask

  task automatic test_len_zero;
    int a0;
    logic [31:0] d;
    a0 = addr_q.size();
    cfg_write(2'd2, 32'd0);
    cfg_write(2'd0, 32'd1);
    wait_cycles(15);
    total++; if (addr_q.size() != a0) begin bad++; $display("FAIL len0_reads got=%0d exp=0", addr_q.size() - a0); end
    cfg_read(2'd3, d);
    total++; if (d !== 32'h8000_0000) begin bad++; $display("FAIL len0_status got=%h exp=80000000", d); end
    cfg_read(2'd0, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL len0_ctrl got=%h exp=0", d); end
    cfg_write(2'd3, 32'd0);
  endtask

  task automatic test_loop;
    int a0, n;
    logic [31:0] d, ea;
    a0 = addr_q.size();
    cfg_write(2'd1, 32'h0000_1000);
    cfg_write(2'd2, 32'd3);
    cfg_write(2'd0, 32'd7);
    n = 0;
    while (addr_q.size() < a0 + 7 && n < 150) begin @(negedge clk_sys); n++; end
    total++;
    if (addr_q.size() < a0 + 7) begin
      bad++; $display("FAIL loop_timeout got=%0d exp=7", addr_q.size() - a0);
    end else begin
      for (int i = 0; i < 7; i++) begin
        ea = 32'h0000_1000 + 32'(4 * (i % 3));
        total++; if (addr_q[a0+i] !== ea) begin bad++; $display("FAIL loop_addr%0d got=%h exp=%h", i, addr_q[a0+i], ea); end
      end
    end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL loop_irq got=%h exp=1", irq); end
    fifo_level = 12'd2000;
    wait_cycles(20);
    cfg_write(2'd3, 32'd0);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL loop_irq_clr got=%h exp=0", irq); end
    cfg_read(2'd3, d);
    total++; if (d[31:30] !== 2'b01) begin bad++; $display("FAIL loop_status_clr got=%h exp=pend0 busy1", d); end
    wait_cycles(20);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL loop_irq_stays got=%h exp=0", irq); end
    cfg_write(2'd0, 32'd0);
    wait_cycles(5);
    cfg_read(2'd3, d);
    total++; if (d[31:30] !== 2'b00) begin bad++; $display("FAIL loop_stop got=%h exp=pend0 busy0", d); end
    fifo_level = 12'd0;
  endtask

  task automatic test_low_water;
    int a0, d0;
    logic [31:0] d, ea;
    a0 = addr_q.size(); d0 = data_q.size();
    fifo_level = 12'd1024;
    cfg_write(2'd1, 32'h0000_1000);
    cfg_write(2'd2, 32'd200);
    cfg_write(2'd0, 32'd1);
    wait_cycles(30);
    total++; if (addr_q.size() != a0 || mem_req !== 1'b0) begin bad++; $display("FAIL lw_no_req got=%0d exp=0", addr_q.size() - a0); end
    cfg_write(2'd1, 32'h0000_2000);
    @(negedge clk_sys); fifo_level = 12'd1023;
    @(negedge clk_sys); fifo_level = 12'd1024;
    wait_cycles(240);
    total++;
    if (addr_q.size() - a0 != 64 || data_q.size() - d0 != 64) begin
      bad++; $display("FAIL lw_count got=%0d/%0d exp=64/64", addr_q.size() - a0, data_q.size() - d0);
    end else begin
      for (int i = 0; i < 64; i += 21) begin
        ea = 32'h0000_1000 + 32'(4 * i);
        total++; if (addr_q[a0+i] !== ea) begin bad++; $display("FAIL lw_addr%0d got=%h exp=%h", i, addr_q[a0+i], ea); end
      end
    end
    cfg_read(2'd3, d);
    total++; if (d !== 32'h4000_0040) begin bad++; $display("FAIL lw_status got=%h exp=40000040", d); end
    cfg_write(2'd0, 32'd0);
    wait_cycles(5);
    cfg_read(2'd3, d);
    total++; if (d !== 32'h0000_0040) begin bad++; $display("FAIL lw_stop got=%h exp=00000040", d); end
    fifo_level = 12'd0;
  endtask

  task automatic test_full_hold;
    int a0, d0;
    logic [31:0] d;
    a0 = addr_q.size(); d0 = data_q.size();
    fifo_full = 1'b1;
    cfg_write(2'd1, 32'h0000_1000);
    cfg_write(2'd2, 32'd2);
    cfg_write(2'd0, 32'd1);
    wait_cycles(16);
    total++; if (addr_q.size() - a0 != 1 || data_q.size() != d0) begin bad++; $display("FAIL full_hold got=%0d/%0d exp=1/0", addr_q.size() - a0, data_q.size() - d0); end
    cfg_read(2'd3, d);
    total++; if (d !== 32'h4000_0000) begin bad++; $display("FAIL full_pos got=%h exp=40000000", d); end
    fifo_full = 1'b0;
    @(negedge clk_sys);
    total++; if (sample_wr !== 1'b1) begin bad++; $display("FAIL full_release_wr got=%h exp=1", sample_wr); end
    total++; if (sample_data !== (32'h0000_1000 ^ PAT)) begin bad++; $display("FAIL full_release_data got=%h exp=%h", sample_data, 32'h0000_1000 ^ PAT); end
    wait_cycles(20);
    total++; if (data_q.size() - d0 != 2) begin bad++; $display("FAIL full_total got=%0d exp=2", data_q.size() - d0); end
    cfg_read(2'd3, d);
    total++; if (d !== 32'h8000_0002) begin bad++; $display("FAIL full_status got=%h exp=80000002", d); end
    cfg_write(2'd3, 32'd0);
  endtask

  task automatic test_disable;
    int a0, d0, n;
    logic [31:0] d;
    a0 = addr_q.size(); d0 = data_q.size();
    ack_wait = 5;
    cfg_write(2'd2, 32'd10);
    cfg_write(2'd0, 32'd1);
    n = 0;
    while (!mem_req && n < 50) begin @(negedge clk_sys); n++; end
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL dis_req_timeout got=%h exp=1", mem_req); end
    cfg_write(2'd0, 32'd0);
    wait_cycles(30);
    total++; if (addr_q.size() - a0 != 1 || data_q.size() - d0 != 1) begin bad++; $display("FAIL dis_count got=%0d/%0d exp=1/1", addr_q.size() - a0, data_q.size() - d0); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL dis_req_low got=%h exp=0", mem_req); end
    cfg_read(2'd3, d);
    total++; if (d !== 32'h0000_0001) begin bad++; $display("FAIL dis_status got=%h exp=00000001", d); end
  endtask

  task automatic test_reset_mid;
    int n;
    logic [31:0] d;
    ack_wait = 5;
    cfg_addr = 2'd1;
    cfg_write(2'd2, 32'd10);
    cfg_write(2'd0, 32'd5);
    n = 0;
    while (!mem_req && n < 50) begin @(negedge clk_sys); n++; end
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL rm_req_timeout got=%h exp=1", mem_req); end
    #2 reset_n = 1'b0;
    #1;
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rm_mem_req got=%h exp=0", mem_req); end
    total++; if (mem_addr !== 32'd0) begin bad++; $display("FAIL rm_mem_addr got=%h exp=0", mem_addr); end
    total++; if (sample_data !== 32'd0) begin bad++; $display("FAIL rm_sample_data got=%h exp=0", sample_data); end
    total++; if (cfg_rdata !== 32'd0 || irq !== 1'b0 || sample_wr !== 1'b0) begin bad++; $display("FAIL rm_outputs got=%h/%h/%h exp=0/0/0", cfg_rdata, irq, sample_wr); end
    @(negedge clk_sys);
    reset_n = 1'b1;
    cfg_read(2'd3, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL rm_status got=%h exp=0", d); end
    cfg_read(2'd1, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL rm_base got=%h exp=0", d); end
  endtask

  initial begin
    reset_n = 1'b0;
    cfg_wr = 1'b0; cfg_addr = 2'd0; cfg_wdata = 32'd0;
    fifo_level = 12'd0; fifo_full = 1'b0;
    wait_cycles(3);
    test_reset;
    test_basic;
    test_len_zero;
    test_loop;
    test_low_water;
    test_full_hold;
    test_disable;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
